// File: rtl/aer_pkg.sv
// Shared types and helpers for the AER event receiver.
package aer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } aer_state_e;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic int ev_xy_w(input int x_w, input int y_w);
        return x_w + y_w;
    endfunction

    function automatic int ev_w(input int x_w, input int y_w, input int ts_w);
        return x_w + y_w + ts_w;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/aer_event_rx_if.sv
// Sensor-side AER handshake bundle and consumer-side event stream bundle.
interface aer_sensor_if #(
    parameter int BUS_W = 9
);
    logic [BUS_W-1:0] aer_bus;
    logic             req_n;
    logic             sel;
    logic             ack_n;

    modport master (output aer_bus, output req_n, output sel, input ack_n);
    modport slave  (input aer_bus, input req_n, input sel, output ack_n);
endinterface

interface aer_event_if #(
    parameter int XY_W = aer_pkg::ev_xy_w(9, 8),
    parameter int TS_W = 32
);
    logic            ev_valid;
    logic            ev_ready;
    logic [XY_W-1:0] ev_xy;
    logic [TS_W-1:0] ev_ts;

    modport master (output ev_valid, output ev_xy, output ev_ts, input ev_ready);
    modport slave  (input ev_valid, input ev_xy, input ev_ts, output ev_ready);
endinterface

// File: rtl/aer_fwft_fifo.sv
// First-word-fall-through FIFO, power-of-two depth.
// Latency: a write is visible on rd_dat the cycle after it is accepted.
// Backpressure: writes are refused only when full and not popping in the same cycle.
module aer_fwft_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;

    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == (AW+1)'(DEPTH));
        pop      = !empty && rd_rdy;
        push     = wr_vld && (!full || pop);
        rd_dat   = empty ? '0 : mem_q[rd_ptr_q];
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; rd_dat is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat;
    end

endmodule

// File: rtl/aer_event_rx.sv
// AER receiver: 4-phase req/ack capture of row/column addresses into timestamped events.
// Latency: ack_n falls SYNC_STAGES+SETTLE_CYC+1 edges after the edge that first samples req_n low.
// Backpressure: the sensor is never stalled; a full FIFO turns column captures into drops.
module aer_event_rx
    import aer_pkg::*;
#(
    parameter int BUS_W        = 9,
    parameter int Y_W          = 8,
    parameter int X_W          = 9,
    parameter int TS_W         = 32,
    parameter int TS_DIV       = 100,
    parameter int SETTLE_CYC   = 40,
    parameter int ACK_HOLD_CYC = 10,
    parameter int SYNC_STAGES  = 2,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    aer_sensor_if.slave sen,
    aer_event_if.master ev,
    output logic [15:0] drop_cnt,
    output logic [15:0] orphan_cnt
);
    localparam int EV_W    = ev_w(X_W, Y_W, TS_W);
    localparam int PS_W    = $clog2(TS_DIV);
    localparam int DLY_MAX = (SETTLE_CYC > ACK_HOLD_CYC) ? SETTLE_CYC : ACK_HOLD_CYC;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);

    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
    logic [SYNC_STAGES-1:0] sel_sync_q, sel_sync_d;
    logic                   req_s, sel_s;
    logic [PS_W-1:0]        psc_q, psc_d;
    logic [TS_W-1:0]        ts_q, ts_d;
    aer_state_e             state_q, state_d;
    logic [DLY_W-1:0]       dly_q, dly_d;
    logic                   sel_lat_q, sel_lat_d;
    logic                   ack_n_q, ack_n_d;
    logic                   y_valid_q, y_valid_d;
    logic [Y_W-1:0]         y_q, y_d;
    logic [15:0]            drop_q, drop_d;
    logic [15:0]            orphan_q, orphan_d;
    logic                   push, pop, hold_done;
    logic                   fifo_full, fifo_empty;
    logic [EV_W-1:0]        fifo_wr_dat, fifo_rd_dat;

    always_comb begin
        req_sync_d = {req_sync_q[SYNC_STAGES-2:0], sen.req_n};
        sel_sync_d = {sel_sync_q[SYNC_STAGES-2:0], sen.sel};
        req_s      = req_sync_q[SYNC_STAGES-1];
        sel_s      = sel_sync_q[SYNC_STAGES-1];

        if (psc_q == PS_W'(TS_DIV - 1)) begin
            psc_d = '0;
            ts_d  = ts_q + 1'b1;
        end else begin
            psc_d = psc_q + 1'b1;
            ts_d  = ts_q;
        end
    end

    assign pop         = !fifo_empty && ev.ev_ready;
    assign fifo_wr_dat = {sen.aer_bus[X_W-1:0], y_q, ts_q};

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        sel_lat_d = sel_lat_q;
        ack_n_d   = ack_n_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        drop_d    = drop_q;
        orphan_d  = orphan_q;
        push      = 1'b0;
        hold_done = (dly_q >= DLY_W'(ACK_HOLD_CYC - 1));

        case (state_q)
            IDLE: begin
                if (!req_s) begin
                    sel_lat_d = sel_s;
                    dly_d     = '0;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (dly_q == DLY_W'(SETTLE_CYC - 1)) begin
                    dly_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            CAPTURE: begin
                // The bus has had SETTLE_CYC cycles to settle; sample it raw.
                if (!sel_lat_q) begin
                    y_d       = sen.aer_bus[Y_W-1:0];
                    y_valid_d = 1'b1;
                end else if (!y_valid_q) begin
                    orphan_d = sat_inc16(orphan_q);
                end else begin
                    push = 1'b1;
                    if (fifo_full && !pop) drop_d = sat_inc16(drop_q);
                end
                ack_n_d = 1'b0;
                dly_d   = '0;
                state_d = ACK;
            end
            ACK: begin
                if (!hold_done) dly_d = dly_q + 1'b1;
                if (hold_done && req_s) begin
                    ack_n_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_sync_q <= '1;
            sel_sync_q <= '0;
            psc_q      <= '0;
            ts_q       <= '0;
            state_q    <= IDLE;
            dly_q      <= '0;
            sel_lat_q  <= 1'b0;
            ack_n_q    <= 1'b1;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            drop_q     <= '0;
            orphan_q   <= '0;
        end else begin
            req_sync_q <= req_sync_d;
            sel_sync_q <= sel_sync_d;
            psc_q      <= psc_d;
            ts_q       <= ts_d;
            state_q    <= state_d;
            dly_q      <= dly_d;
            sel_lat_q  <= sel_lat_d;
            ack_n_q    <= ack_n_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            drop_q     <= drop_d;
            orphan_q   <= orphan_d;
        end
    end

    aer_fwft_fifo #(
        .W     (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (push),
        .wr_dat (fifo_wr_dat),
        .rd_rdy (ev.ev_ready),
        .rd_dat (fifo_rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign sen.ack_n   = ack_n_q;
    assign ev.ev_valid = !fifo_empty;
    assign ev.ev_xy    = fifo_rd_dat[EV_W-1:TS_W];
    assign ev.ev_ts    = fifo_rd_dat[TS_W-1:0];
    assign drop_cnt    = drop_q;
    assign orphan_cnt  = orphan_q;

endmodule

// File: tb/tb_aer_event_rx.sv
// Randomised and directed bench for aer_event_rx against an event-level reference model.
module tb_aer_event_rx;
    localparam int BUS_W        = 9;
    localparam int Y_W          = 8;
    localparam int X_W          = 9;
    localparam int TS_W         = 4;
    localparam int TS_DIV       = 2;
    localparam int SETTLE_CYC   = 3;
    localparam int ACK_HOLD_CYC = 4;
    localparam int SYNC_STAGES  = 2;
    localparam int FIFO_DEPTH   = 4;

    typedef struct packed {
        logic [X_W+Y_W-1:0] xy;
        logic [TS_W-1:0]    ts;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] drop_cnt, orphan_cnt;

    always #5 clk = ~clk;

    aer_sensor_if #(.BUS_W(BUS_W)) sen_if ();
    aer_event_if #(.XY_W(X_W + Y_W), .TS_W(TS_W)) ev_if ();

    aer_event_rx #(
        .BUS_W(BUS_W), .Y_W(Y_W), .X_W(X_W), .TS_W(TS_W), .TS_DIV(TS_DIV),
        .SETTLE_CYC(SETTLE_CYC), .ACK_HOLD_CYC(ACK_HOLD_CYC),
        .SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sen        (sen_if),
        .ev         (ev_if),
        .drop_cnt   (drop_cnt),
        .orphan_cnt (orphan_cnt)
    );

    int             n_vec = 0;
    int             n_bad = 0;
    int             cyc = 0;
    ev_t            exp_q[$];
    logic           y_valid_m;
    logic [Y_W-1:0] y_m;
    int             drop_m, orphan_m;

    // Edges seen since reset was last released.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Timestamp held after k edges: one tick every TS_DIV edges, wrapping at 2^TS_W.
    function automatic logic [TS_W-1:0] ts_at(input int k);
        return TS_W'((k / TS_DIV) % (1 << TS_W));
    endfunction

    function automatic int max2(input int p, input int q);
        return (p > q) ? p : q;
    endfunction

    always @(negedge clk) begin
        if (!reset && ev_if.ev_valid && ev_if.ev_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", ev_if.ev_valid, 1'b0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_xy", ev_if.ev_xy, e.xy);
                chk("ev_ts", ev_if.ev_ts, e.ts);
            end
        end
    end

    task automatic model_clear();
        exp_q.delete();
        y_valid_m = 1'b0;
        y_m       = '0;
        drop_m    = 0;
        orphan_m  = 0;
    endtask

    // One full sensor handshake; pop_at_cap pulses ev_ready for exactly the capture edge.
    task automatic xfer(input logic s, input logic [BUS_W-1:0] addr, input int hold_extra,
                        input bit pop_at_cap);
        int a, r, rel, seen;
        bit found;
        sen_if.aer_bus = addr;
        sen_if.sel     = s;
        sen_if.req_n   = 1'b0;
        a     = cyc + SYNC_STAGES + SETTLE_CYC + 2;
        found = 1'b0;
        seen  = -1;
        for (int i = 0; i < 200 && !found; i++) begin
            if (pop_at_cap && cyc == a - 1) ev_if.ev_ready = 1'b1;
            tick();
            if (pop_at_cap && cyc == a) ev_if.ev_ready = 1'b0;
            if (sen_if.ack_n == 1'b0) begin
                found = 1'b1;
                seen  = cyc;
            end
        end
        chk("ack_fall", seen, a);

        if (s == 1'b0) begin
            y_m       = addr[Y_W-1:0];
            y_valid_m = 1'b1;
        end else if (!y_valid_m) begin
            if (orphan_m < 65535) orphan_m++;
        end else if (exp_q.size() >= FIFO_DEPTH) begin
            if (drop_m < 65535) drop_m++;
        end else begin
            exp_q.push_back({addr[X_W-1:0], y_m, ts_at(a - 1)});
        end
        chk("ev_valid", ev_if.ev_valid, exp_q.size() != 0);
        chk("drop_cnt", drop_cnt, drop_m);
        chk("orphan_cnt", orphan_cnt, orphan_m);

        repeat (hold_extra) tick();
        chk("ack_held", sen_if.ack_n, 1'b0);
        sen_if.req_n = 1'b1;
        r     = cyc;
        rel   = max2(a + ACK_HOLD_CYC, r + SYNC_STAGES + 1);
        found = 1'b0;
        seen  = -1;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (sen_if.ack_n == 1'b1) begin
                found = 1'b1;
                seen  = cyc;
            end
        end
        chk("ack_rise", seen, rel);
        repeat (2) tick();
    endtask

    task automatic drain();
        ev_if.ev_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        tick();
        chk("drain_left", exp_q.size(), 0);
        chk("drain_valid", ev_if.ev_valid, 1'b0);
    endtask

    task automatic align_ts(input logic [TS_W-1:0] want);
        for (int i = 0; i < 100 && ts_at(cyc + SYNC_STAGES + SETTLE_CYC + 1) != want; i++)
            tick();
    endtask

    initial begin
        int drop_base, seen;
        bit found;
        reset          = 1'b1;
        sen_if.req_n   = 1'b1;
        sen_if.sel     = 1'b0;
        sen_if.aer_bus = '0;
        ev_if.ev_ready = 1'b1;
        model_clear();
        repeat (3) tick();

        chk("rst_ack_n", sen_if.ack_n, 1'b1);
        chk("rst_ev_valid", ev_if.ev_valid, 1'b0);
        chk("rst_ev_xy", ev_if.ev_xy, 0);
        chk("rst_ev_ts", ev_if.ev_ts, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_orphan", orphan_cnt, 0);
        reset = 1'b0;

        // Column with no row yet.
        xfer(1'b1, 9'h010, 0, 1'b0);
        chk("orphan_one", orphan_cnt, 1);

        // Basic row then column, aligned to timestamp 7.
        xfer(1'b0, 9'h02A, 0, 1'b0);
        align_ts(4'd7);
        xfer(1'b1, 9'h105, 0, 1'b0);
        drain();

        // Slow sensor holds req_n low long after ack.
        xfer(1'b1, 9'h0C3, 100, 1'b0);
        drain();

        // Timestamp wrap: one event at 15, the next after the wrap.
        align_ts(4'd15);
        xfer(1'b1, 9'h111, 0, 1'b0);
        xfer(1'b1, 9'h122, 0, 1'b0);
        drain();

        // Overflow: FIFO_DEPTH+3 columns with no consumer.
        ev_if.ev_ready = 1'b0;
        drop_base = drop_m;
        for (int i = 0; i < FIFO_DEPTH + 3; i++)
            xfer(1'b1, BUS_W'($urandom), 0, 1'b0);
        chk("overflow_drops", drop_cnt, drop_base + 3);
        // Full FIFO with a pop on the capture edge accepts the push.
        xfer(1'b1, 9'h1F0, 0, 1'b1);
        chk("full_pop_push", drop_cnt, drop_base + 3);
        drain();

        // Randomised traffic with random back-pressure and sensor speed.
        for (int i = 0; i < 40; i++) begin
            ev_if.ev_ready = ($urandom_range(0, 3) != 0);
            xfer(($urandom_range(0, 2) != 0), BUS_W'($urandom), $urandom_range(0, 6), 1'b0);
        end
        drain();

        // Reset while ack_n is low, with events pending in the FIFO.
        ev_if.ev_ready = 1'b0;
        xfer(1'b1, 9'h0AB, 0, 1'b0);
        xfer(1'b1, 9'h0CD, 0, 1'b0);
        sen_if.aer_bus = 9'h033;
        sen_if.sel     = 1'b0;
        sen_if.req_n   = 1'b0;
        found = 1'b0;
        seen  = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (sen_if.ack_n == 1'b0) found = 1'b1;
        end
        chk("rst_mid_ack_low", sen_if.ack_n, 1'b0);
        reset        = 1'b1;
        sen_if.req_n = 1'b1;
        tick();
        chk("rst_mid_ack_n", sen_if.ack_n, 1'b1);
        chk("rst_mid_valid", ev_if.ev_valid, 1'b0);
        chk("rst_mid_drop", drop_cnt, 0);
        chk("rst_mid_orphan", orphan_cnt, 0);
        reset = 1'b0;
        model_clear();
        ev_if.ev_ready = 1'b1;
        tick();
        xfer(1'b1, 9'h077, 0, 1'b0);
        xfer(1'b0, 9'h055, 0, 1'b0);
        xfer(1'b1, 9'h1AA, 0, 1'b0);
        drain();

        chk("final_drop", drop_cnt, drop_m);
        chk("final_orphan", orphan_cnt, orphan_m);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_bad);
        $fatal(1);
    end

endmodule
